e_mdu_issue: RTL and testbench

- E-stage issue controller directly upstream of the multiply/divide unit (MDU).
- Accepts one MDU-class instruction per handshake from the D/E pipeline:
  - mult, multu, div, divu, mthi, mtlo, mfhi, mflo.
- Sequences Start/MDUSelect/A/B into the MDU and tracks its Busy flag, including the one-cycle gap before Busy rises.
- Stalls the decode stage while the MDU is occupied; returns mfhi/mflo results to the E/M register.

---
 rtl/e_mdu_issue_pkg.sv | 37 +++
 rtl/e_mdu_issue_if.sv | 36 +++
 rtl/e_mdu_issue.sv | 107 ++++++++++
 tb/tb_e_mdu_issue.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_issue_pkg.sv
// Shared definitions for the E-stage MDU issue controller and the MDU itself:
// op codes, the idle MDUSelect value and the issue FSM state encoding.
package e_mdu_issue_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101,
    MDU_MFHI  = 3'b110,
    MDU_MFLO  = 3'b111
  } mdu_op_e;

  // Driven on MDUSelect when nothing is issued; the MDU ignores it without Start.
  localparam logic [2:0] MDU_IDLE_SEL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_BUSY = 2'b10
  } issue_state_e;

  function automatic logic is_arith(input mdu_op_e op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
  endfunction

  function automatic logic is_move_to(input mdu_op_e op);
    return op inside {MDU_MTHI, MDU_MTLO};
  endfunction

  function automatic logic is_move_from(input mdu_op_e op);
    return op inside {MDU_MFHI, MDU_MFLO};
  endfunction

endpackage

// File: rtl/e_mdu_issue_if.sv
// Bus bundle between the D/E pipeline, the issue controller and the MDU.
// The slave modport is the issue controller's view; master is its environment.
interface e_mdu_issue_if #(
  parameter int DW = 32
);
  // D/E pipeline side
  logic          in_valid;
  logic [2:0]    in_op;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_ready;
  logic          flush;
  logic          stall_d;
  // MDU side
  logic          mdu_start;
  logic [2:0]    mdu_sel;
  logic [DW-1:0] mdu_a;
  logic [DW-1:0] mdu_b;
  logic          mdu_busy;
  logic [DW-1:0] mdu_hi;
  logic [DW-1:0] mdu_lo;
  // E/M result side
  logic          rd_valid;
  logic [DW-1:0] rd_data;

  modport slave (
    input  in_valid, in_op, in_a, in_b, flush, mdu_busy, mdu_hi, mdu_lo,
    output in_ready, stall_d, mdu_start, mdu_sel, mdu_a, mdu_b, rd_valid, rd_data
  );

  modport master (
    output in_valid, in_op, in_a, in_b, flush, mdu_busy, mdu_hi, mdu_lo,
    input  in_ready, stall_d, mdu_start, mdu_sel, mdu_a, mdu_b, rd_valid, rd_data
  );

endinterface

// File: rtl/e_mdu_issue.sv
// E-stage issue controller for the multiply/divide unit: accepts one MDU op per
// handshake, sequences Start/MDUSelect/A/B, tracks Busy and returns mfhi/mflo.
module e_mdu_issue
  import e_mdu_issue_pkg::*;
#(
  parameter int         DW       = 32,
  parameter logic [2:0] IDLE_SEL = MDU_IDLE_SEL  // must not be 3'b100 or 3'b101
) (
  input logic         clk,
  input logic         reset,
  e_mdu_issue_if.slave bus
);

  issue_state_e  state_q, state_d;
  mdu_op_e       op;
  logic          in_ready;
  logic          accept;

  logic          start_q;
  logic [2:0]    sel_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] hi_view;
  logic [DW-1:0] lo_view;

  assign op       = mdu_op_e'(bus.in_op);
  assign in_ready = (state_q == ST_IDLE) & ~bus.mdu_busy & ~bus.flush & ~reset;
  assign accept   = bus.in_valid & in_ready;

  // An mt* issued last cycle lands in the MDU on this edge, so an mf* accepted
  // now would see the stale register; take the value straight from mdu_a.
  assign hi_view = (sel_q == MDU_MTHI) ? a_q : bus.mdu_hi;
  assign lo_view = (sel_q == MDU_MTLO) ? a_q : bus.mdu_lo;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && is_arith(op)) state_d = ST_PEND;
      // PEND covers the cycle before the MDU's registered Busy rises.
      ST_PEND: state_d = ST_BUSY;
      ST_BUSY: if (!bus.mdu_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue and result registers: Start/MDUSelect and rd_valid are one-cycle
  // pulses; operands and rd_data hold their last value between issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q    <= 1'b0;
      sel_q      <= IDLE_SEL;
      a_q        <= '0;
      b_q        <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      start_q    <= 1'b0;
      sel_q      <= IDLE_SEL;
      rd_valid_q <= 1'b0;
      if (accept) begin
        if (is_arith(op)) begin
          start_q <= 1'b1;
          sel_q   <= op;
          a_q     <= bus.in_a;
          b_q     <= bus.in_b;
        end else if (is_move_to(op)) begin
          sel_q   <= op;
          a_q     <= bus.in_a;
        end else if (is_move_from(op)) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= (op == MDU_MFHI) ? hi_view : lo_view;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.stall_d   = bus.in_valid & ~in_ready;
  assign bus.mdu_start = start_q;
  assign bus.mdu_sel   = sel_q;
  assign bus.mdu_a     = a_q;
  assign bus.mdu_b     = b_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

  // The MDU would treat Start with an mt* select as a register write plus an op.
  a_no_start_on_move: assert property (@(posedge clk) disable iff (reset)
    !(start_q && (sel_q == MDU_MTHI || sel_q == MDU_MTLO)));

  a_start_single_cycle: assert property (@(posedge clk) disable iff (reset)
    start_q |=> !start_q);

endmodule

// File: tb/tb_e_mdu_issue.sv
// Directed bench for e_mdu_issue with a behavioural MDU (5-cycle mult, 10-cycle
// div) and a scoreboard of expected mfhi/mflo results.
module tb_e_mdu_issue;
  import e_mdu_issue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  e_mdu_issue_if #(.DW(32)) bus ();

  e_mdu_issue #(.DW(32), .IDLE_SEL(3'b111)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural MDU: Busy rises the cycle after Start and stays high for
  // latency-1 cycles; mthi/mtlo write on the edge that sees the select.
  logic [3:0]  m_cnt;
  logic [31:0] m_hi, m_lo;
  logic signed [63:0] m_sprod;
  logic [63:0] m_uprod;

  assign bus.mdu_busy = (m_cnt != 4'd0);
  assign bus.mdu_hi   = m_hi;
  assign bus.mdu_lo   = m_lo;
  assign m_sprod = $signed({{32{bus.mdu_a[31]}}, bus.mdu_a}) * $signed({{32{bus.mdu_b[31]}}, bus.mdu_b});
  assign m_uprod = {32'd0, bus.mdu_a} * {32'd0, bus.mdu_b};

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 4'd0;
      m_hi  <= 32'd0;
      m_lo  <= 32'd0;
    end else begin
      if (m_cnt != 4'd0) m_cnt <= m_cnt - 4'd1;
      if (bus.mdu_start) begin
        case (bus.mdu_sel)
          3'b000: begin {m_hi, m_lo} <= m_sprod; m_cnt <= 4'd4; end
          3'b001: begin {m_hi, m_lo} <= m_uprod; m_cnt <= 4'd4; end
          3'b010: begin
            if (bus.mdu_b != 32'd0) begin
              m_lo <= $signed(bus.mdu_a) / $signed(bus.mdu_b);
              m_hi <= $signed(bus.mdu_a) % $signed(bus.mdu_b);
            end
            m_cnt <= 4'd9;
          end
          3'b011: begin
            if (bus.mdu_b != 32'd0) begin
              m_lo <= bus.mdu_a / bus.mdu_b;
              m_hi <= bus.mdu_a % bus.mdu_b;
            end
            m_cnt <= 4'd9;
          end
          default: ;
        endcase
      end else if (bus.mdu_sel == 3'b100) begin
        m_hi <= bus.mdu_a;
      end else if (bus.mdu_sel == 3'b101) begin
        m_lo <= bus.mdu_a;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    #1;
  endtask

  // Advance one clock; every cycle rd_valid must match scoreboard occupancy.
  task automatic tick();
    logic [31:0] exp;
    @(posedge clk);
    #1;
    chk("rd_valid", bus.rd_valid, sb.size() != 0);
    if (bus.rd_valid && sb.size() != 0) begin
      exp = sb.pop_front();
      chk("rd_data", bus.rd_data, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    bus.flush    = 1'b0;
    drive(1'b0, MDU_MULT, 32'd0, 32'd0);
    tick();
    tick();
    chk("rst_start", bus.mdu_start, 1'b0);
    chk("rst_sel", bus.mdu_sel, 3'b111);
    chk("rst_a", bus.mdu_a, 32'd0);
    chk("rst_b", bus.mdu_b, 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_stall", bus.stall_d, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", bus.in_ready, 1'b1);

    // mult -3 * 7, stalled mflo waiting behind it
    drive(1'b1, MDU_MULT, 32'hFFFF_FFFD, 32'd7);
    chk("mult_ready", bus.in_ready, 1'b1);
    tick();
    chk("mult_start", bus.mdu_start, 1'b1);
    chk("mult_sel", bus.mdu_sel, 3'b000);
    chk("mult_a", bus.mdu_a, 32'hFFFF_FFFD);
    chk("mult_b", bus.mdu_b, 32'd7);
    chk("mult_c1_ready", bus.in_ready, 1'b0);
    drive(1'b1, MDU_MFLO, 32'd0, 32'd0);
    chk("mult_c1_stall", bus.stall_d, 1'b1);
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk("mult_busy_ready", bus.in_ready, 1'b0);
      chk("mult_busy_stall", bus.stall_d, 1'b1);
      chk("mult_busy_start", bus.mdu_start, 1'b0);
      chk("mult_busy_sel", bus.mdu_sel, 3'b111);
    end
    chk("mult_a_hold", bus.mdu_a, 32'hFFFF_FFFD);
    tick();
    chk("mult_c7_ready", bus.in_ready, 1'b1);
    sb.push_back(32'hFFFF_FFEB);
    tick();
    drive(1'b1, MDU_MFHI, 32'd0, 32'd0);
    chk("mfhi_ready", bus.in_ready, 1'b1);
    sb.push_back(32'hFFFF_FFFF);
    tick();
    drive(1'b0, MDU_MULT, 32'd0, 32'd0);

    // divu 100 / 7
    drive(1'b1, MDU_DIVU, 32'd100, 32'd7);
    chk("divu_ready", bus.in_ready, 1'b1);
    tick();
    chk("divu_start", bus.mdu_start, 1'b1);
    chk("divu_sel", bus.mdu_sel, 3'b011);
    chk("divu_c1_ready", bus.in_ready, 1'b0);
    drive(1'b1, MDU_MFHI, 32'd0, 32'd0);
    for (int c = 2; c <= 11; c++) begin
      tick();
      chk("divu_busy_ready", bus.in_ready, 1'b0);
    end
    tick();
    chk("divu_c12_ready", bus.in_ready, 1'b1);
    sb.push_back(32'd2);
    tick();
    drive(1'b1, MDU_MFLO, 32'd0, 32'd0);
    sb.push_back(32'd14);
    tick();
    drive(1'b0, MDU_MULT, 32'd0, 32'd0);

    // mthi then mfhi on the very next cycle
    drive(1'b1, MDU_MTHI, 32'h0000_1234, 32'h0000_DEAD);
    chk("mthi_ready", bus.in_ready, 1'b1);
    tick();
    chk("mthi_sel", bus.mdu_sel, 3'b100);
    chk("mthi_start", bus.mdu_start, 1'b0);
    chk("mthi_a", bus.mdu_a, 32'h0000_1234);
    chk("mthi_b_hold", bus.mdu_b, 32'd7);
    drive(1'b1, MDU_MFHI, 32'd0, 32'd0);
    chk("mfhi_b2b_ready", bus.in_ready, 1'b1);
    sb.push_back(32'h0000_1234);
    tick();
    chk("mfhi_b2b_sel", bus.mdu_sel, 3'b111);
    chk("mfhi_b2b_start", bus.mdu_start, 1'b0);

    // mtlo, mthi, mflo, mfhi on consecutive cycles
    drive(1'b1, MDU_MTLO, 32'h0000_CAFE, 32'd0);
    tick();
    chk("mtlo_sel", bus.mdu_sel, 3'b101);
    drive(1'b1, MDU_MTHI, 32'h0000_5555, 32'd0);
    tick();
    chk("mthi2_sel", bus.mdu_sel, 3'b100);
    drive(1'b1, MDU_MFLO, 32'd0, 32'd0);
    sb.push_back(32'h0000_CAFE);
    tick();
    drive(1'b1, MDU_MFHI, 32'd0, 32'd0);
    sb.push_back(32'h0000_5555);
    tick();
    drive(1'b0, MDU_MULT, 32'd0, 32'd0);

    // flush blocks acceptance, but an issued mult runs to completion
    drive(1'b1, MDU_MULT, 32'd6, 32'd7);
    bus.flush = 1'b1;
    #1;
    chk("flush_idle_ready", bus.in_ready, 1'b0);
    chk("flush_idle_stall", bus.stall_d, 1'b1);
    tick();
    chk("flush_no_start", bus.mdu_start, 1'b0);
    chk("flush_no_sel", bus.mdu_sel, 3'b111);
    bus.flush = 1'b0;
    #1;
    chk("flush_release_ready", bus.in_ready, 1'b1);
    tick();
    chk("flush_mult_start", bus.mdu_start, 1'b1);
    drive(1'b1, MDU_MFLO, 32'd0, 32'd0);
    tick();
    bus.flush = 1'b1;
    #1;
    for (int c = 2; c <= 4; c++) begin
      chk("flush_busy_ready", bus.in_ready, 1'b0);
      chk("flush_busy_stall", bus.stall_d, 1'b1);
      if (c < 4) tick();
    end
    bus.flush = 1'b0;
    tick();
    chk("flush_c5_ready", bus.in_ready, 1'b0);
    tick();
    chk("flush_c6_ready", bus.in_ready, 1'b0);
    tick();
    chk("flush_c7_ready", bus.in_ready, 1'b1);
    sb.push_back(32'd42);
    tick();
    drive(1'b0, MDU_MULT, 32'd0, 32'd0);

    // reset while BUSY abandons the divide
    drive(1'b1, MDU_DIV, 32'd100, 32'd7);
    tick();
    chk("rdiv_start", bus.mdu_start, 1'b1);
    drive(1'b0, MDU_MULT, 32'd0, 32'd0);
    tick();
    tick();
    chk("rdiv_busy_ready", bus.in_ready, 1'b0);
    reset = 1'b1;
    tick();
    chk("rbusy_start", bus.mdu_start, 1'b0);
    chk("rbusy_sel", bus.mdu_sel, 3'b111);
    chk("rbusy_a", bus.mdu_a, 32'd0);
    chk("rbusy_ready_in_reset", bus.in_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("rbusy_ready", bus.in_ready, 1'b1);
    tick();
    chk("rbusy_ready_next", bus.in_ready, 1'b1);

    // idle 20 cycles: select parked, HI/LO untouched
    drive(1'b1, MDU_MTHI, 32'h0000_A5A5, 32'd0);
    tick();
    drive(1'b1, MDU_MTLO, 32'h0000_5A5A, 32'd0);
    tick();
    drive(1'b0, MDU_MFHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_sel", bus.mdu_sel, 3'b111);
      chk("idle_start", bus.mdu_start, 1'b0);
    end
    drive(1'b1, MDU_MFHI, 32'd0, 32'd0);
    sb.push_back(32'h0000_A5A5);
    tick();
    drive(1'b1, MDU_MFLO, 32'd0, 32'd0);
    sb.push_back(32'h0000_5A5A);
    tick();
    drive(1'b0, MDU_MULT, 32'd0, 32'd0);
    tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
